vd_frame_io_ctrl: RTL

- Parametrised frame I/O controller for the Viterbi decoder datapath.
- Replaces the divided-clock IIB/OIB pair with a single-clock block driven by a clock-enable tick.
- Input side: captures a codeword frame and streams it to the decoder as SYM_W-bit symbols, one per tick.
- Output side: collects decoded bits into an OUT_BITS word, and flags a timeout if the decoder stalls.

---
 rtl/vd_frame_io_ctrl_if.sv | 29 ++
 rtl/vd_frame_io_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/vd_frame_io_ctrl_if.sv
// Frame I/O controller bus: host start/frame, decoder symbol/bit streams, status.
// slave = controller side, master = host/decoder side.
interface vd_frame_io_ctrl_if #(
    parameter int SYM_W      = 2,
    parameter int FRAME_SYMS = 8,
    parameter int OUT_BITS   = 8
);
    logic                        i_start;
    logic [SYM_W*FRAME_SYMS-1:0] i_frame;
    logic [SYM_W-1:0]            o_sym;
    logic                        o_sym_valid;
    logic                        i_dec_bit;
    logic                        i_dec_valid;
    logic [OUT_BITS-1:0]         o_word;
    logic                        o_word_valid;
    logic                        o_error;
    logic                        o_busy;
    logic                        o_tick;

    modport slave (
        input  i_start, i_frame, i_dec_bit, i_dec_valid,
        output o_sym, o_sym_valid, o_word, o_word_valid, o_error, o_busy, o_tick
    );

    modport master (
        output i_start, i_frame, i_dec_bit, i_dec_valid,
        input  o_sym, o_sym_valid, o_word, o_word_valid, o_error, o_busy, o_tick
    );
endinterface

// File: rtl/vd_frame_io_ctrl.sv
// Single-clock frame I/O controller for the Viterbi decoder: streams a captured
// codeword out one symbol per tick and collects decoded bits into a word, with a
// stall timeout while waiting for the decoder.
module vd_frame_io_ctrl #(
    parameter int SYM_W         = 2,
    parameter int FRAME_SYMS    = 8,
    parameter int OUT_BITS      = 8,
    parameter int TICK_DIV      = 25,
    parameter int TIMEOUT_TICKS = 64
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    vd_frame_io_ctrl_if.slave  io
);
    localparam int FW  = SYM_W * FRAME_SYMS;
    localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCW = $clog2(FRAME_SYMS + 1);
    localparam int BCW = $clog2(OUT_BITS + 1);
    localparam int OCW = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_DEC, DONE} state_t;
    state_t state_q, state_d;

    logic [TCW-1:0]      tick_cnt_q;
    logic                tick;
    logic                start_q, armed_q, start_edge;
    logic [FW-1:0]       shreg_q;
    logic [SCW-1:0]      sym_cnt_q;
    logic [BCW-1:0]      bit_cnt_q;
    logic [OCW-1:0]      to_cnt_q;
    logic [SYM_W-1:0]    sym_q;
    logic                sym_vld_q;
    logic [OUT_BITS-1:0] word_q;
    logic                word_vld_q, err_q;

    logic busy, launch, bit_acc, last_bit, send_now, last_sym, to_hit;

    // Free-running symbol tick divider; with TICK_DIV=1 the tick is always high
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  tick_cnt_q <= '0;
        else if (tick) tick_cnt_q <= '0;
        else           tick_cnt_q <= tick_cnt_q + TCW'(1);
    end
    assign tick = (tick_cnt_q == TCW'(TICK_DIV - 1));

    // Start edge detect; armed_q blocks a level held high across reset from launching
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            start_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            start_q <= io.i_start;
            armed_q <= armed_q | ~io.i_start;
        end
    end
    assign start_edge = io.i_start & ~start_q & armed_q;

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next state; final decoded bit beats both last symbol and timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start_edge) state_d = SEND;
            SEND: begin
                if (last_bit)      state_d = DONE;
                else if (last_sym) state_d = WAIT_DEC;
            end
            WAIT_DEC: begin
                if (last_bit || to_hit) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: busy flag and frame launch qualification
    always_comb begin
        busy   = 1'b0;
        launch = 1'b0;
        case (state_q)
            IDLE, DONE:     launch = start_edge;
            SEND, WAIT_DEC: busy   = 1'b1;
            default:        ;
        endcase
    end

    assign bit_acc  = busy && io.i_dec_valid && (bit_cnt_q < BCW'(OUT_BITS));
    assign last_bit = bit_acc && (bit_cnt_q == BCW'(OUT_BITS - 1));
    // A completed word abandons the rest of the frame, even on a tick
    assign send_now = (state_q == SEND) && tick && !last_bit;
    assign last_sym = send_now && (sym_cnt_q == SCW'(FRAME_SYMS - 1));
    // Any decoder activity resets the stall window, so it cannot coincide with a bit
    assign to_hit   = (state_q == WAIT_DEC) && !io.i_dec_valid && tick &&
                      (to_cnt_q == OCW'(TIMEOUT_TICKS - 1));

    // Datapath: frame capture, symbol shift-out, bit collection, stall timer, status
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shreg_q    <= '0;
            sym_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            to_cnt_q   <= '0;
            sym_q      <= '0;
            sym_vld_q  <= 1'b0;
            word_q     <= '0;
            word_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sym_vld_q <= send_now;
            if (launch) begin
                shreg_q    <= io.i_frame;
                sym_cnt_q  <= '0;
                bit_cnt_q  <= '0;
                to_cnt_q   <= '0;
                word_q     <= '0;
                word_vld_q <= 1'b0;
                err_q      <= 1'b0;
            end
            if (send_now) begin
                sym_q     <= shreg_q[FW-1 -: SYM_W];
                shreg_q   <= shreg_q << SYM_W;
                sym_cnt_q <= sym_cnt_q + SCW'(1);
            end
            if (bit_acc) begin
                word_q    <= OUT_BITS'({word_q, io.i_dec_bit});
                bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
            if (last_bit) word_vld_q <= 1'b1;
            if (state_q == WAIT_DEC) begin
                if (io.i_dec_valid) to_cnt_q <= '0;
                else if (tick)      to_cnt_q <= to_cnt_q + OCW'(1);
            end
            if (to_hit) err_q <= 1'b1;
        end
    end

    assign io.o_sym        = sym_q;
    assign io.o_sym_valid  = sym_vld_q;
    assign io.o_word       = word_q;
    assign io.o_word_valid = word_vld_q;
    assign io.o_error      = err_q;
    assign io.o_busy       = busy;
    assign io.o_tick       = tick;
endmodule
